// File: rtl/lsu_pkg.sv
//-----------------------------------------------------------------------------
// lsu_pkg : shared funct3 codes, FSM state type and byte-enable helper
// Revision: 1.0
//-----------------------------------------------------------------------------
`default_nettype none

package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    WAIT_R = 2'd2,
    RESP   = 2'd3
  } lsu_state_t;

  // Store byte enables; word accesses are always aligned so off is ignored there.
  function automatic logic [3:0] be_for(input logic [2:0] funct3, input logic [1:0] off);
    logic [3:0] be;
    case (funct3)
      F3_B:    be = 4'b0001 << off;
      F3_H:    be = 4'b0011 << off;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

endpackage

`default_nettype wire

// File: rtl/lsu_load_extract.sv
//-----------------------------------------------------------------------------
// lsu_load_extract : lane shift plus sign/zero extension of a loaded word
// Revision: 1.0
//-----------------------------------------------------------------------------
`default_nettype none

module lsu_load_extract
  import lsu_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  off,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);

  logic [31:0] w_shifted;

  assign w_shifted = rdata >> {off, 3'b000};

  always_comb begin
    data = '0;
    case (funct3)
      F3_B:    data = {{24{w_shifted[7]}}, w_shifted[7:0]};
      F3_H:    data = {{16{w_shifted[15]}}, w_shifted[15:0]};
      F3_W:    data = rdata;
      F3_BU:   data = {24'b0, w_shifted[7:0]};
      F3_HU:   data = {16'b0, w_shifted[15:0]};
      default: data = '0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/load_store_unit.sv
//-----------------------------------------------------------------------------
// load_store_unit : single-outstanding MEM-stage initiator for the data memory
// Revision: 1.0
//-----------------------------------------------------------------------------
`default_nettype none

module load_store_unit
  import lsu_pkg::*;
#(
  parameter int DM_ADDRESS = 9,
  parameter int DATA_W     = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [31:0]           req_addr,
  input  logic [DATA_W-1:0]     req_wdata,
  input  logic [2:0]            req_funct3,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_W-1:0]     resp_rdata,
  output logic                  resp_err,
  output logic                  mem_req,
  input  logic                  mem_gnt,
  output logic                  mem_we,
  output logic [DM_ADDRESS-1:0] mem_addr,
  output logic [3:0]            mem_be,
  output logic [DATA_W-1:0]     mem_wdata,
  input  logic                  mem_rvalid,
  input  logic [DATA_W-1:0]     mem_rdata
);

  lsu_state_t        r_state;
  logic [1:0]        r_off;
  logic [2:0]        r_funct3;
  logic              w_illegal;
  logic [DATA_W-1:0] w_wdata;
  logic [DATA_W-1:0] w_load_data;
  logic              w_unused_addr;

  assign w_unused_addr = ^req_addr[31:DM_ADDRESS];

  // Handshake outputs decode state only, so reset drops them without a clock.
  assign req_ready  = (r_state == IDLE);
  assign mem_req    = (r_state == ISSUE);
  assign resp_valid = (r_state == RESP);

  always_comb begin
    w_illegal = 1'b0;
    if (req_we) begin
      if (!(req_funct3 inside {F3_B, F3_H, F3_W})) w_illegal = 1'b1;
    end else begin
      if (!(req_funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU})) w_illegal = 1'b1;
    end
    if (req_funct3[1:0] == 2'b01 && req_addr[0]) w_illegal = 1'b1;
    if (req_funct3[1:0] == 2'b10 && req_addr[1:0] != 2'b00) w_illegal = 1'b1;
  end

  always_comb begin
    w_wdata = req_wdata;
    case (req_funct3)
      F3_B:    w_wdata = {4{req_wdata[7:0]}};
      F3_H:    w_wdata = {2{req_wdata[15:0]}};
      default: w_wdata = req_wdata;
    endcase
  end

  lsu_load_extract u_extract (
    .rdata  (mem_rdata),
    .off    (r_off),
    .funct3 (r_funct3),
    .data   (w_load_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_off      <= '0;
      r_funct3   <= '0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_be     <= '0;
      mem_wdata  <= '0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (req_valid) begin
            r_off      <= req_addr[1:0];
            r_funct3   <= req_funct3;
            resp_rdata <= '0;
            resp_err   <= w_illegal;
            if (w_illegal) begin
              r_state <= RESP;
            end else begin
              mem_we    <= req_we;
              mem_addr  <= {req_addr[DM_ADDRESS-1:2], 2'b00};
              mem_be    <= req_we ? be_for(req_funct3, req_addr[1:0]) : 4'b1111;
              mem_wdata <= req_we ? w_wdata : '0;
              r_state   <= ISSUE;
            end
          end
        end
        ISSUE: begin
          if (mem_gnt) r_state <= mem_we ? RESP : WAIT_R;
        end
        WAIT_R: begin
          if (mem_rvalid) begin
            resp_rdata <= w_load_data;
            r_state    <= RESP;
          end
        end
        RESP: begin
          if (resp_ready) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_load_store_unit.sv
//-----------------------------------------------------------------------------
// tb_load_store_unit : directed vectors for load_store_unit
// Revision: 1.0
//-----------------------------------------------------------------------------
`default_nettype none

module tb_load_store_unit;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [2:0]  req_funct3;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_req;
  logic        mem_gnt;
  logic        mem_we;
  logic [8:0]  mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  int n_tests = 0;
  int n_fail  = 0;

  load_store_unit #(.DM_ADDRESS(9), .DATA_W(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_funct3 (req_funct3),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_req    (mem_req),
    .mem_gnt    (mem_gnt),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_be     (mem_be),
    .mem_wdata  (mem_wdata),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h required 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd);
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wd;
    tick();
    req_valid  = 1'b0;
  endtask

  task automatic finish_resp(input string tag);
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    check({tag, "_ready_after"}, 32'(req_ready), 32'd1);
  endtask

  task automatic do_store(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [3:0] exp_be,
                          input logic [31:0] exp_wd, input logic [31:0] exp_addr);
    start(1'b1, f3, addr, wd);
    check({tag, "_req"}, 32'(mem_req), 32'd1);
    check({tag, "_we"}, 32'(mem_we), 32'd1);
    check({tag, "_be"}, 32'(mem_be), 32'(exp_be));
    check({tag, "_wdata"}, mem_wdata, exp_wd);
    check({tag, "_addr"}, 32'(mem_addr), exp_addr);
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    check({tag, "_rvld"}, 32'(resp_valid), 32'd1);
    check({tag, "_err"}, 32'(resp_err), 32'd0);
    check({tag, "_rdata"}, resp_rdata, 32'd0);
    finish_resp(tag);
  endtask

  task automatic do_load(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] rd, input logic [31:0] exp_addr,
                         input logic [31:0] exp);
    start(1'b0, f3, addr, 32'h0);
    check({tag, "_req"}, 32'(mem_req), 32'd1);
    check({tag, "_we"}, 32'(mem_we), 32'd0);
    check({tag, "_be"}, 32'(mem_be), 32'hF);
    check({tag, "_addr"}, 32'(mem_addr), exp_addr);
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    check({tag, "_req_drop"}, 32'(mem_req), 32'd0);
    check({tag, "_rvld_early"}, 32'(resp_valid), 32'd0);
    mem_rvalid = 1'b1;
    mem_rdata  = rd;
    tick();
    mem_rvalid = 1'b0;
    mem_rdata  = 32'h5A5A5A5A;
    check({tag, "_rvld"}, 32'(resp_valid), 32'd1);
    check({tag, "_err"}, 32'(resp_err), 32'd0);
    check({tag, "_rdata"}, resp_rdata, exp);
    finish_resp(tag);
  endtask

  task automatic do_err(input string tag, input logic we, input logic [2:0] f3,
                        input logic [31:0] addr);
    start(we, f3, addr, 32'hFFFFFFFF);
    check({tag, "_rvld"}, 32'(resp_valid), 32'd1);
    check({tag, "_err"}, 32'(resp_err), 32'd1);
    check({tag, "_req"}, 32'(mem_req), 32'd0);
    check({tag, "_rdata"}, resp_rdata, 32'd0);
    finish_resp(tag);
  endtask

  initial begin
    rst_n      = 1'b0;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_addr   = '0;
    req_wdata  = '0;
    req_funct3 = '0;
    resp_ready = 1'b0;
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
    #1;
    check("rst_ready", 32'(req_ready), 32'd1);
    check("rst_req", 32'(mem_req), 32'd0);
    check("rst_we", 32'(mem_we), 32'd0);
    check("rst_be", 32'(mem_be), 32'd0);
    check("rst_addr", 32'(mem_addr), 32'd0);
    check("rst_wdata", mem_wdata, 32'd0);
    check("rst_rvld", 32'(resp_valid), 32'd0);
    check("rst_rdata", resp_rdata, 32'd0);
    check("rst_err", 32'(resp_err), 32'd0);
    #11;
    rst_n = 1'b1;
    tick();

    // Stores
    do_store("sb3", 3'b000, 32'h0000_0003, 32'h0000_00A5, 4'b1000, 32'hA5A5A5A5, 32'h000);
    do_store("sh2", 3'b001, 32'h0000_000A, 32'h1234_ABCD, 4'b1100, 32'hABCDABCD, 32'h008);
    do_store("sbhi", 3'b000, 32'hABCD_1244, 32'h0000_007F, 4'b0001, 32'h7F7F7F7F, 32'h044);

    // Loads
    do_load("lb6", 3'b000, 32'h006, 32'h12F03456, 32'h004, 32'hFFFFFFF0);
    do_load("lbu6", 3'b100, 32'h006, 32'h12F03456, 32'h004, 32'h000000F0);
    do_load("lhu6", 3'b101, 32'h006, 32'h12F03456, 32'h004, 32'h000012F0);
    do_load("lb1", 3'b000, 32'h001, 32'h12F03456, 32'h000, 32'h00000034);
    do_load("lh0", 3'b001, 32'h040, 32'h00008001, 32'h040, 32'hFFFF8001);

    // Illegal accesses
    do_err("lw_mis", 1'b0, 3'b010, 32'h102);
    do_err("ld_f3_011", 1'b0, 3'b011, 32'h100);
    do_err("lh_mis", 1'b0, 3'b001, 32'h001);
    do_err("st_f3_100", 1'b1, 3'b100, 32'h000);

    // SW with grant held off for three cycles
    start(1'b1, 3'b010, 32'h1FC, 32'hDEADBEEF);
    for (int i = 0; i < 4; i++) begin
      check("swd_req", 32'(mem_req), 32'd1);
      check("swd_addr", 32'(mem_addr), 32'h1FC);
      check("swd_be", 32'(mem_be), 32'hF);
      check("swd_wdata", mem_wdata, 32'hDEADBEEF);
      check("swd_we", 32'(mem_we), 32'd1);
      check("swd_rvld_early", 32'(resp_valid), 32'd0);
      mem_gnt = (i == 3);
      tick();
    end
    mem_gnt = 1'b0;
    check("swd_rvld", 32'(resp_valid), 32'd1);
    check("swd_req_drop", 32'(mem_req), 32'd0);
    finish_resp("swd");

    // LW with late rvalid and slow consumer
    start(1'b0, 3'b010, 32'h010, 32'h0);
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    mem_rdata = 32'h11111111;
    for (int i = 0; i < 5; i++) begin
      check("lwd_wait_rvld", 32'(resp_valid), 32'd0);
      tick();
    end
    mem_rvalid = 1'b1;
    mem_rdata  = 32'hCAFEF00D;
    tick();
    mem_rvalid = 1'b0;
    mem_rdata  = 32'h0;
    for (int i = 0; i < 3; i++) begin
      check("lwd_rvld", 32'(resp_valid), 32'd1);
      check("lwd_rdata", resp_rdata, 32'hCAFEF00D);
      check("lwd_ready_low", 32'(req_ready), 32'd0);
      resp_ready = (i == 2);
      tick();
    end
    resp_ready = 1'b0;
    check("lwd_ready", 32'(req_ready), 32'd1);
    check("lwd_rvld_drop", 32'(resp_valid), 32'd0);

    // Reset while waiting for read data
    start(1'b0, 3'b010, 32'h020, 32'h0);
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_req", 32'(mem_req), 32'd0);
    check("mid_rst_rvld", 32'(resp_valid), 32'd0);
    check("mid_rst_ready", 32'(req_ready), 32'd1);
    check("mid_rst_be", 32'(mem_be), 32'd0);
    #1;
    rst_n = 1'b1;
    tick();
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h87654321;
    tick();
    mem_rvalid = 1'b0;
    check("stale_rvld", 32'(resp_valid), 32'd0);
    check("stale_ready", 32'(req_ready), 32'd1);
    check("stale_rdata", resp_rdata, 32'd0);

    do_load("post_rst", 3'b101, 32'h086, 32'hBEEF0000, 32'h084, 32'h0000BEEF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
